// File: rtl/pipelined_control.sv
// RV32I decode plus ID/EX, EX/MEM, MEM/WB control pipeline with hazard and forwarding logic.
// Optional macro CTRL_FORWARD_EN enables EX operand forwarding; without it RAW hazards stall instead.
module pipelined_control #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUCTRL_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  input  logic [31:0]           instruction,
  input  logic                  stall_ext,
  input  logic                  flush,
  output logic                  id_stall,
  output logic                  id_illegal,
  output logic                  ex_valid,
  output logic [ALUCTRL_W-1:0]  ex_AluCtrl,
  output logic                  ex_AluSrc,
  output logic [XLEN-1:0]       ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_branch,
  output logic                  ex_jal,
  output logic                  ex_jalr,
  output logic                  ex_auipc,
  output logic                  ex_lui,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  mem_valid,
  output logic                  mem_MemRead,
  output logic                  mem_MemWrite,
  output logic                  mem_RegWrite,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  wb_valid,
  output logic                  wb_RegWrite,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [1:0]            wb_ResultSrc
);

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I      = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111
  } opcode_e;

  typedef struct packed {
    logic                  valid;
    logic [ALUCTRL_W-1:0]  alu_ctrl;
    logic                  alu_src;
    logic [XLEN-1:0]       imm;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  branch;
    logic                  jal;
    logic                  jalr;
    logic                  auipc;
    logic                  lui;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic [1:0]            result_src;
  } idex_t;

  typedef struct packed {
    logic                  valid;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
    logic [1:0]            result_src;
  } exmem_t;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
    logic [1:0]            result_src;
  } memwb_t;

  idex_t  ex_q,  ex_d;
  exmem_t mem_q, mem_d;
  memwb_t wb_q,  wb_d;
  idex_t  dec;

  logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
  logic known;
  logic [2:0]  f3;
  logic        alt;
  logic [31:0] imm32;
  logic        load_use, raw_hazard, hazard;

  assign f3 = instruction[14:12];

  always_comb begin
    {is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc} = '0;
    case (instruction[6:0])
      OP_R:      is_r      = 1'b1;
      OP_I:      is_i      = 1'b1;
      OP_LOAD:   is_load   = 1'b1;
      OP_STORE:  is_store  = 1'b1;
      OP_BRANCH: is_branch = 1'b1;
      OP_JAL:    is_jal    = 1'b1;
      OP_JALR:   is_jalr   = 1'b1;
      OP_LUI:    is_lui    = 1'b1;
      OP_AUIPC:  is_auipc  = 1'b1;
      default:   ;
    endcase
  end

  assign known = is_r | is_i | is_load | is_store | is_branch | is_jal | is_jalr | is_lui | is_auipc;

  // alt is the SUB/SRA selector bit of funct7 (instruction bit 30)
  assign alt = (is_r | (is_i & ((f3 == 3'b001) | (f3 == 3'b101)))) & instruction[30];

  always_comb begin
    if (is_store)
      imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    else if (is_branch)
      imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
               instruction[30:25], instruction[11:8], 1'b0};
    else if (is_lui | is_auipc)
      imm32 = {instruction[31:12], 12'b0};
    else if (is_jal)
      imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
               instruction[20], instruction[30:21], 1'b0};
    else
      imm32 = {{20{instruction[31]}}, instruction[31:20]};
  end

  always_comb begin
    dec            = '0;
    dec.valid      = 1'b1;
    dec.alu_ctrl   = (is_r | is_i | is_branch) ? ALUCTRL_W'({alt, f3}) : '0;
    dec.alu_src    = is_i | is_load | is_store | is_jalr | is_lui | is_auipc;
    dec.imm        = XLEN'($signed(imm32));
    // unused source fields are zeroed so they never match a producer
    dec.rs1        = (is_lui | is_auipc | is_jal) ? '0 : REG_ADDR_W'(instruction[19:15]);
    dec.rs2        = (is_r | is_store | is_branch) ? REG_ADDR_W'(instruction[24:20]) : '0;
    dec.rd         = REG_ADDR_W'(instruction[11:7]);
    dec.branch     = is_branch;
    dec.jal        = is_jal;
    dec.jalr       = is_jalr;
    dec.auipc      = is_auipc;
    dec.lui        = is_lui;
    dec.mem_read   = is_load;
    dec.mem_write  = is_store;
    dec.reg_write  = ~(is_store | is_branch) & (instruction[11:7] != 5'd0);
    dec.result_src = is_load ? 2'b01 : ((is_jal | is_jalr) ? 2'b10 : 2'b00);
    if (!(instr_valid & known))
      dec = '0;
  end

  assign load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
                    (((dec.rs1 != '0) & (dec.rs1 == ex_q.rd)) |
                     ((dec.rs2 != '0) & (dec.rs2 == ex_q.rd)));

`ifdef CTRL_FORWARD_EN
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                         input exmem_t m, input memwb_t w);
    if (m.valid & m.reg_write & (m.rd != '0) & (m.rd == rs))
      return 2'b10;
    else if (w.valid & w.reg_write & (w.rd != '0) & (w.rd == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign raw_hazard = 1'b0;
  assign fwd_a      = fwd_sel(ex_q.rs1, mem_q, wb_q);
  assign fwd_b      = fwd_sel(ex_q.rs2, mem_q, wb_q);
`else
  // Without forwarding, hold ID until every producer of a used source has reached WB
  function automatic logic src_hit(input logic [REG_ADDR_W-1:0] rs, input idex_t e,
                                   input exmem_t m);
    return (rs != '0) &
           ((e.valid & e.reg_write & (e.rd == rs)) | (m.valid & m.reg_write & (m.rd == rs)));
  endfunction

  assign raw_hazard = src_hit(dec.rs1, ex_q, mem_q) | src_hit(dec.rs2, ex_q, mem_q);
  assign fwd_a      = 2'b00;
  assign fwd_b      = 2'b00;
`endif

  assign hazard     = load_use | raw_hazard;
  assign id_stall   = rst_n & (stall_ext | (~flush & hazard));
  assign id_illegal = rst_n & instr_valid & ~known;

  always_comb begin
    ex_d           = (flush | hazard) ? '0 : dec;
    mem_d          = '0;
    mem_d.valid      = ex_q.valid;
    mem_d.mem_read   = ex_q.mem_read;
    mem_d.mem_write  = ex_q.mem_write;
    mem_d.reg_write  = ex_q.reg_write;
    mem_d.rd         = ex_q.rd;
    mem_d.result_src = ex_q.result_src;
    wb_d           = '0;
    wb_d.valid       = mem_q.valid;
    wb_d.reg_write   = mem_q.reg_write;
    wb_d.rd          = mem_q.rd;
    wb_d.result_src  = mem_q.result_src;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!stall_ext) begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_AluCtrl   = ex_q.alu_ctrl;
  assign ex_AluSrc    = ex_q.alu_src;
  assign ex_imm       = ex_q.imm;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign ex_branch    = ex_q.branch;
  assign ex_jal       = ex_q.jal;
  assign ex_jalr      = ex_q.jalr;
  assign ex_auipc     = ex_q.auipc;
  assign ex_lui       = ex_q.lui;
  assign mem_valid    = mem_q.valid;
  assign mem_MemRead  = mem_q.mem_read;
  assign mem_MemWrite = mem_q.mem_write;
  assign mem_RegWrite = mem_q.reg_write;
  assign mem_rd       = mem_q.rd;
  assign wb_valid     = wb_q.valid;
  assign wb_RegWrite  = wb_q.reg_write;
  assign wb_rd        = wb_q.rd;
  assign wb_ResultSrc = wb_q.result_src;

endmodule

// File: tb/tb_pipelined_control.sv
// Directed-vector bench for pipelined_control; expectations follow CTRL_FORWARD_EN when defined.
module tb_pipelined_control;

`ifdef CTRL_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [31:0] LW_X5      = 32'h0000A283;
  localparam logic [31:0] ADD_X6     = 32'h00228333;
  localparam logic [31:0] ADD_X3     = 32'h002081B3;
  localparam logic [31:0] SUB_X4     = 32'h40318233;
  localparam logic [31:0] ADD_X8     = 32'h00018433;
  localparam logic [31:0] ADDI_X0    = 32'h00508013;
  localparam logic [31:0] ADD_X7     = 32'h000003B3;
  localparam logic [31:0] BEQ_M4     = 32'hFE000EE3;
  localparam logic [31:0] ADDI_X1    = 32'h00500093;
  localparam logic [31:0] LUI_X9     = 32'h123454B7;
  localparam logic [31:0] SRAI_X5    = 32'h4032D293;
  localparam logic [31:0] ADDI_NEG   = 32'hC0000093;
  localparam logic [31:0] JAL_X1     = 32'h008000EF;
  localparam logic [31:0] SW_X2      = 32'h0020A423;
  localparam logic [31:0] ILLEGAL    = 32'h0000007F;

  logic        clk = 1'b0;
  logic        rst_n, instr_valid, stall_ext, flush;
  logic [31:0] instruction;
  logic        id_stall, id_illegal, ex_valid, ex_AluSrc;
  logic [3:0]  ex_AluCtrl;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic        ex_branch, ex_jal, ex_jalr, ex_auipc, ex_lui;
  logic [1:0]  fwd_a, fwd_b, wb_ResultSrc;
  logic        mem_valid, mem_MemRead, mem_MemWrite, mem_RegWrite, wb_valid, wb_RegWrite;

  int n_vec = 0;
  int n_err = 0;

  pipelined_control #(.XLEN(32), .REG_ADDR_W(5), .ALUCTRL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instruction(instruction),
    .stall_ext(stall_ext), .flush(flush), .id_stall(id_stall), .id_illegal(id_illegal),
    .ex_valid(ex_valid), .ex_AluCtrl(ex_AluCtrl), .ex_AluSrc(ex_AluSrc), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_branch(ex_branch), .ex_jal(ex_jal),
    .ex_jalr(ex_jalr), .ex_auipc(ex_auipc), .ex_lui(ex_lui), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_valid(mem_valid), .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_RegWrite(mem_RegWrite), .mem_rd(mem_rd), .wb_valid(wb_valid),
    .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_ResultSrc(wb_ResultSrc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    instr_valid = 1'b0;
    repeat (3) tick();
  endtask

  // Present instr in ID, wait out id_stall (bounded), then let it enter EX.
  task automatic issue(input logic [31:0] instr, input int exp_stalls, input string tag);
    int stalls;
    instruction = instr;
    instr_valid = 1'b1;
    #1;
    stalls = 0;
    while (id_stall && stalls < 8) begin
      stalls++;
      tick();
    end
    check(tag, stalls, exp_stalls);
    tick();
    instr_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b1;
    instruction = ILLEGAL;
    stall_ext   = 1'b0;
    flush       = 1'b0;
    #2;
    check("rst_ex_valid",  ex_valid,   0);
    check("rst_mem_valid", mem_valid,  0);
    check("rst_wb_valid",  wb_valid,   0);
    check("rst_id_stall",  id_stall,   0);
    check("rst_illegal",   id_illegal, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n       = 1'b1;
    instr_valid = 1'b0;
    tick();

    // load-use
    instruction = LW_X5; instr_valid = 1'b1;
    #1 check("lw_nostall", id_stall, 0);
    tick();
    check("lw_ex_rd", ex_rd, 5);
    check("lw_alusrc", ex_AluSrc, 1);
    instruction = ADD_X6;
    #1 check("lu_stall", id_stall, 1);
    tick();
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_mem_read", mem_MemRead, 1);
    check("lu_stall2", id_stall, FWD ? 0 : 1);
    if (!FWD) tick();
    tick();
    check("lu_add_valid", ex_valid, 1);
    check("lu_add_rd", ex_rd, 6);
    check("lu_fwd_a", fwd_a, FWD ? 2'b01 : 2'b00);
    check("lu_fwd_b", fwd_b, 2'b00);
    check("lu_wb_res", wb_ResultSrc, FWD ? 2'b01 : 2'b00);
    drain();

    // back-to-back ALU dependency
    issue(ADD_X3, 0, "add3_stalls");
    issue(SUB_X4, FWD ? 0 : 2, "sub_stalls");
    check("sub_fwd_a", fwd_a, FWD ? 2'b10 : 2'b00);
    check("sub_fwd_b", fwd_b, FWD ? 2'b10 : 2'b00);
    check("sub_aluctrl", ex_AluCtrl, 4'b1000);
    check("sub_alusrc", ex_AluSrc, 0);
    issue(ADD_X8, 0, "add8_stalls");
    check("add8_fwd_a", fwd_a, FWD ? 2'b01 : 2'b00);
    check("add8_fwd_b", fwd_b, 2'b00);
    drain();

    // x0 destination never writes or forwards
    issue(ADDI_X0, 0, "addi_x0_stalls");
    issue(ADD_X7, 0, "x0_stalls");
    check("x0_fwd_a", fwd_a, 2'b00);
    check("x0_fwd_b", fwd_b, 2'b00);
    check("x0_mem_valid", mem_valid, 1);
    check("x0_mem_regwrite", mem_RegWrite, 0);
    tick();
    check("x0_wb_valid", wb_valid, 1);
    check("x0_wb_regwrite", wb_RegWrite, 0);
    drain();

    // branch immediate and flush
    issue(BEQ_M4, 0, "beq_stalls");
    check("beq_imm", ex_imm, 32'hFFFFFFFC);
    check("beq_branch", ex_branch, 1);
    check("beq_aluctrl", ex_AluCtrl, 4'b0000);
    check("beq_alusrc", ex_AluSrc, 0);
    instruction = ADDI_X1; instr_valid = 1'b1; flush = 1'b1;
    #1 check("flush_id_stall", id_stall, 0);
    tick();
    flush = 1'b0; instr_valid = 1'b0;
    check("flush_ex_valid", ex_valid, 0);
    check("flush_mem_valid", mem_valid, 1);
    check("flush_mem_regwrite", mem_RegWrite, 0);
    tick();
    check("flush_addi_gone", mem_valid, 0);
    drain();

    // external stall with concurrent flush
    issue(ADDI_X1, 0, "addi_x1_stalls");
    stall_ext = 1'b1; flush = 1'b1; instruction = LUI_X9; instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("sx_id_stall", id_stall, 1);
      tick();
      check("sx_ex_valid", ex_valid, 1);
      check("sx_ex_rd", ex_rd, 1);
      check("sx_ex_imm", ex_imm, 32'h5);
      check("sx_mem_valid", mem_valid, 0);
      check("sx_wb_valid", wb_valid, 0);
    end
    stall_ext = 1'b0;
    #1 check("sx_rel_stall", id_stall, 0);
    tick();
    flush = 1'b0; instr_valid = 1'b0;
    check("sx_rel_ex_valid", ex_valid, 0);
    check("sx_rel_mem_valid", mem_valid, 1);
    check("sx_rel_mem_rd", mem_rd, 1);
    tick();
    check("sx_mem_empty", mem_valid, 0);
    check("sx_wb_valid2", wb_valid, 1);
    check("sx_wb_rd", wb_rd, 1);
    check("sx_wb_regwrite", wb_RegWrite, 1);
    check("sx_wb_res", wb_ResultSrc, 2'b00);
    drain();

    // decode corners
    instruction = ILLEGAL; instr_valid = 1'b1;
    #1 check("ill_flag", id_illegal, 1);
    tick();
    instr_valid = 1'b0;
    check("ill_bubble", ex_valid, 0);
    issue(SRAI_X5, 0, "srai_stalls");
    check("srai_aluctrl", ex_AluCtrl, 4'b1101);
    issue(ADDI_NEG, 0, "addineg_stalls");
    check("addineg_aluctrl", ex_AluCtrl, 4'b0000);
    check("addineg_imm", ex_imm, 32'hFFFFFC00);
    drain();
    issue(JAL_X1, 0, "jal_stalls");
    check("jal_flag", ex_jal, 1);
    check("jal_imm", ex_imm, 32'h8);
    tick();
    tick();
    check("jal_wb_res", wb_ResultSrc, 2'b10);
    check("jal_wb_rd", wb_rd, 1);
    drain();
    issue(SW_X2, 0, "sw_stalls");
    check("sw_imm", ex_imm, 32'h8);
    check("sw_alusrc", ex_AluSrc, 1);
    tick();
    check("sw_memwrite", mem_MemWrite, 1);
    check("sw_regwrite", mem_RegWrite, 0);
    drain();
    issue(LUI_X9, 0, "lui_stalls");
    check("lui_flag", ex_lui, 1);
    check("lui_imm", ex_imm, 32'h12345000);
    drain();

    // reset mid-stream
    issue(ADDI_X1, 0, "pre_rst1");
    issue(LUI_X9, 0, "pre_rst2");
    #2 rst_n = 1'b0;
    #1;
    check("mrst_ex_valid", ex_valid, 0);
    check("mrst_mem_valid", mem_valid, 0);
    check("mrst_wb_valid", wb_valid, 0);
    check("mrst_id_stall", id_stall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_ex_valid", ex_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
